instr_fetch: RTL

- Fetch stage directly upstream of decode/register file: owns the PC, issues in-order word reads to instruction memory and buffers returned instructions with their PCs.
- Presents instructions to decode over a valid/ready handshake; accepts redirects (branch/jump) from execute and discards stale in-flight fetches.
- Replaces the bare pc + insMem pairing with a latency-tolerant front end.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 56 +++++
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC, NOP encoding,
// PC step, fetch buffer entry layout and the fetch FSM state type.
// FETCH_MISALIGN_EN adds a misalign flag to each buffered fetch entry.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INSN_W = 32;

    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [DEF_INSN_W-1:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [DEF_ADDR_W-1:0] PC_INC       = 32'd4;

    // One buffered instruction together with the PC it was fetched from
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INSN_W-1:0] insn;
`ifdef FETCH_MISALIGN_EN
        logic                  misalign;
`endif
    } fetch_entry_t;

    typedef enum logic {
        FETCH    = 1'b0,
        MISALIGN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries, DEPTH deep (power of two).
// Ports: clk, reset (sync, active-high), push/push_entry, pop, flush,
//        occ (entry count), head (entry at read pointer), empty.
// Flush wins over push; a pop on an empty FIFO is ignored.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   occ,
    output fetch_entry_t             head,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    // Pointer and count bookkeeping
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign occ   = count;
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word reads under a
// credit limit of BUF_DEPTH (buffered + in flight), buffers responses with
// their PCs and hands them to decode over valid/ready. Redirects flush the
// buffer and drop responses of fetches already in flight.
// Ports: clk, reset (sync, active-high); redirect_valid/redirect_pc from
//        execute; req_valid/req_ready/req_addr to imem; resp_valid/resp_data
//        from imem; insn_valid/insn_ready/insn_data/insn_pc to decode.
// FETCH_MISALIGN_EN: adds insn_misalign; a misaligned redirect yields one
//        flagged entry and stalls fetch until the next redirect.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       INSN_W    = DEF_INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [INSN_W-1:0] resp_data,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [INSN_W-1:0] insn_data,
`ifdef FETCH_MISALIGN_EN
    output logic              insn_misalign,
`endif
    output logic [ADDR_W-1:0] insn_pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  occ;
    logic [ADDR_W-1:0] redir_pc;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              empty;
    logic              push;
    logic              pop;
    logic              req_fire;
    logic              credit_ok;
    logic              stall;
    logic              mis_push;

    assign redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign credit_ok = (SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH);
    assign req_valid = !reset && !redirect_valid && credit_ok && !stall;
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;

    assign insn_valid = !reset && !empty;
    assign insn_data  = insn_valid ? INSN_W'(head.insn) : '0;
    assign insn_pc    = insn_valid ? ADDR_W'(head.pc) : '0;
    assign pop        = insn_valid && insn_ready;

`ifdef FETCH_MISALIGN_EN
    fetch_state_t      state;
    logic              mis_pending;
    logic [ADDR_W-1:0] mis_pc;

    assign stall         = (state == MISALIGN);
    assign mis_push      = stall && mis_pending && (discard == '0);
    assign insn_misalign = insn_valid && head.misalign;

    // Misalign FSM: park on a misaligned target, emit one flagged entry
    // once the stale fetches have drained, then wait for a new redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            mis_pending <= 1'b0;
            mis_pc      <= '0;
        end else if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state       <= MISALIGN;
                mis_pending <= 1'b1;
                mis_pc      <= redirect_pc;
            end else begin
                state       <= FETCH;
                mis_pending <= 1'b0;
            end
        end else if (mis_push) begin
            mis_pending <= 1'b0;
        end
    end
`else
    logic unused_low_bits;

    assign stall           = 1'b0;
    assign mis_push        = 1'b0;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

    // Buffer write: live response, or the synthetic misalign entry
    always_comb begin
        push_entry      = '0;
        push_entry.pc   = DEF_ADDR_W'(resp_pc);
        push_entry.insn = DEF_INSN_W'(resp_data);
        push            = resp_valid && (discard == '0);
`ifdef FETCH_MISALIGN_EN
        if (mis_push) begin
            push_entry.pc       = DEF_ADDR_W'(mis_pc);
            push_entry.insn     = '0;
            push_entry.misalign = 1'b1;
            push                = 1'b1;
        end
`endif
    end

    // PC, in-flight and discard tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_valid);
            if (redirect_valid) begin
                // Everything still outstanding after this cycle is stale
                discard  <= inflight - CNT_W'(resp_valid);
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                if (resp_valid) begin
                    if (discard != '0) discard <= discard - CNT_W'(1);
                    else               resp_pc <= resp_pc + ADDR_W'(PC_INC);
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .occ        (occ),
        .head       (head),
        .empty      (empty)
    );

    // A response with nothing outstanding would overrun the credit scheme
    assert property (@(posedge clk) disable iff (reset)
                     resp_valid |-> (inflight != '0));

endmodule
